// File: rtl/decode_stage_mw.sv
// Multi-issue decode stage: splits each fetch bundle into in-order issue groups at intra-bundle RAW hazards.
// Optional DEC_R0_ZERO_EN: r0 always reads as zero and never creates a RAW hazard.
module decode_stage_mw #(
  parameter int unsigned LANES      = 2,
  parameter int unsigned XLEN       = 16,
  parameter int unsigned RAW_W      = 3,
  parameter logic [3:0]  OPC_BRANCH = 4'hD,
  parameter logic [3:0]  OPC_STORE  = 4'hE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*16-1:0]        in_instr,
  input  logic [XLEN-1:0]            in_pc,
  output logic [LANES*2*RAW_W-1:0]   rf_raddr,
  input  logic [LANES*2*XLEN-1:0]    rf_rdata,
  output logic [LANES-1:0]           out_valid,
  input  logic                       out_ready,
  output logic [LANES*4-1:0]         out_opcode,
  output logic [LANES*RAW_W-1:0]     out_rd,
  output logic [LANES*5-1:0]         out_imm,
  output logic [LANES-1:0]           out_imm_flag,
  output logic [LANES*XLEN-1:0]      out_op1,
  output logic [LANES*XLEN-1:0]      out_op2,
  output logic [LANES*XLEN-1:0]      out_branch_target
);

  typedef enum logic {S_IDLE, S_SPLIT} state_e;

  state_e                   state_q, state_d;
  logic [LANES*16-1:0]      held_q, held_d;
  logic [XLEN-1:0]          hpc_q, hpc_d;
  logic [2:0]               start_q, start_d;
  logic [LANES-1:0]         ov_q, ov_d;
  logic [LANES*4-1:0]       opc_q, opc_d;
  logic [LANES*RAW_W-1:0]   rd_q, rd_d;
  logic [LANES*5-1:0]       imm_q, imm_d;
  logic [LANES-1:0]         iflag_q, iflag_d;
  logic [LANES*XLEN-1:0]    op1_q, op1_d, op2_q, op2_d, bt_q, bt_d;

  logic [LANES*16-1:0]      src_instr;
  logic [XLEN-1:0]          src_pc;
  logic [15:0]              ins;
  logic [4:0]               imm_raw;
  logic [XLEN-1:0]          sext;
  logic [XLEN-1:0]          rs1_data, rs2_data;
  logic [3:0]               l_opc [LANES];
  logic [RAW_W-1:0]         l_rd  [LANES];
  logic [RAW_W-1:0]         l_rs1 [LANES];
  logic [RAW_W-1:0]         l_rs2 [LANES];
  logic                     l_if  [LANES];
  logic                     l_wr  [LANES];
  logic [4:0]               l_imm [LANES];
  logic [XLEN-1:0]          l_op1 [LANES];
  logic [XLEN-1:0]          l_op2 [LANES];
  logic [XLEN-1:0]          l_bt  [LANES];

  int unsigned              base, k;
  logic                     found, advance, issue;

  always_comb begin
    src_instr = (state_q == S_SPLIT) ? held_q : in_instr;
    src_pc    = (state_q == S_SPLIT) ? hpc_q  : in_pc;
    rf_raddr  = '0;
    ins       = '0;
    imm_raw   = '0;
    sext      = '0;
    rs1_data  = '0;
    rs2_data  = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      ins        = src_instr[16*l +: 16];
      l_opc[l]   = ins[15:12];
      l_rd[l]    = RAW_W'(ins[11:9]);
      l_rs1[l]   = RAW_W'(ins[8:6]);
      l_rs2[l]   = RAW_W'(ins[4:2]);
      l_if[l]    = ins[5];
      rf_raddr[(2*l)*RAW_W   +: RAW_W] = l_rs1[l];
      rf_raddr[(2*l+1)*RAW_W +: RAW_W] = l_rs2[l];
      rs1_data   = rf_rdata[(2*l)*XLEN   +: XLEN];
      rs2_data   = rf_rdata[(2*l+1)*XLEN +: XLEN];
`ifdef DEC_R0_ZERO_EN
      if (l_rs1[l] == '0) rs1_data = '0;
      if (l_rs2[l] == '0) rs2_data = '0;
      l_wr[l]    = (l_opc[l] != 4'h0) && (l_opc[l] != OPC_BRANCH) &&
                   (l_opc[l] != OPC_STORE) && (l_rd[l] != '0);
`else
      l_wr[l]    = (l_opc[l] != 4'h0) && (l_opc[l] != OPC_BRANCH) &&
                   (l_opc[l] != OPC_STORE);
`endif
      imm_raw    = ins[5] ? ins[4:0] : 5'h00;
      sext       = {{(XLEN-5){imm_raw[4]}}, imm_raw};
      l_imm[l]   = imm_raw;
      l_op1[l]   = rs1_data;
      l_op2[l]   = ins[5] ? sext : rs2_data;
      l_bt[l]    = (l_opc[l] == OPC_BRANCH) ? (src_pc + XLEN'(l) + sext) : '0;
    end
  end

  // First lane at or after the group start that consumes an earlier in-group result.
  always_comb begin
    base  = (state_q == S_SPLIT) ? 32'(start_q) : 0;
    k     = LANES;
    found = 1'b0;
    for (int unsigned kk = 1; kk < LANES; kk++) begin
      for (int unsigned j = 0; j < kk; j++) begin
        if (!found && kk > base && j >= base && l_wr[j] &&
            (l_rs1[kk] == l_rd[j] || (!l_if[kk] && l_rs2[kk] == l_rd[j]))) begin
          found = 1'b1;
          k     = kk;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    held_d   = held_q;
    hpc_d    = hpc_q;
    start_d  = start_q;
    ov_d     = ov_q;
    opc_d    = opc_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    iflag_d  = iflag_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    bt_d     = bt_q;
    advance  = !(|ov_q) || out_ready;
    in_ready = reset && (state_q == S_IDLE) && advance && !flush;
    issue    = (state_q == S_IDLE) ? (in_valid && in_ready) : (advance && !flush);

    if (flush || issue || advance) begin
      ov_d = '0; opc_d = '0; rd_d = '0; imm_d = '0;
      iflag_d = '0; op1_d = '0; op2_d = '0; bt_d = '0;
    end

    if (flush) begin
      state_d = S_IDLE;
      held_d  = '0;
      hpc_d   = '0;
      start_d = '0;
    end else if (issue) begin
      // Lanes base..k-1 are compacted down to slot 0.
      for (int unsigned s = 0; s < LANES; s++) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          if (l == base + s && l < k) begin
            ov_d[s]                 = 1'b1;
            opc_d[4*s +: 4]         = l_opc[l];
            rd_d[RAW_W*s +: RAW_W]  = l_rd[l];
            imm_d[5*s +: 5]         = l_imm[l];
            iflag_d[s]              = l_if[l];
            op1_d[XLEN*s +: XLEN]   = l_op1[l];
            op2_d[XLEN*s +: XLEN]   = l_op2[l];
            bt_d[XLEN*s +: XLEN]    = l_bt[l];
          end
        end
      end
      if (k == LANES) begin
        state_d = S_IDLE;
        held_d  = '0;
        hpc_d   = '0;
        start_d = '0;
      end else begin
        state_d = S_SPLIT;
        start_d = 3'(k);
        if (state_q == S_IDLE) begin
          held_d = in_instr;
          hpc_d  = in_pc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      held_q  <= '0;
      hpc_q   <= '0;
      start_q <= '0;
      ov_q    <= '0;
      opc_q   <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      iflag_q <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      bt_q    <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      hpc_q   <= hpc_d;
      start_q <= start_d;
      ov_q    <= ov_d;
      opc_q   <= opc_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      iflag_q <= iflag_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      bt_q    <= bt_d;
    end
  end

  assign out_valid         = ov_q;
  assign out_opcode        = opc_q;
  assign out_rd            = rd_q;
  assign out_imm           = imm_q;
  assign out_imm_flag      = iflag_q;
  assign out_op1           = op1_q;
  assign out_op2           = op2_q;
  assign out_branch_target = bt_q;

endmodule

// File: doc/decode_stage_mw.md
Name: decode_stage_mw

Overview:
- Parametrised multi-issue successor to the single-lane decode unit in the superscalar pipeline.
- Accepts a bundle of LANES 16-bit instructions from fetch and reads operands from the register file.
- Detects intra-bundle RAW hazards and splits the bundle into in-order issue groups over several cycles.
- Presents registered decoded lanes to issue through a valid/ready handshake; flush (branch taken) kills all in-flight state.

Parameters:
- LANES, 2, instructions per bundle; legal 1..4.
- XLEN, 16, data/PC width.
- RAW_W, 3, register address width (8 architectural registers).
- OPC_BRANCH, 4'hD, opcode treated as branch.
- OPC_STORE, 4'hE, opcode that does not write rd.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  branch taken; synchronous kill.
- in_valid  in  1  fetch bundle valid.
- in_ready  out  1  decode can accept the bundle this cycle.
- in_instr  in  LANES*16  lane i at [16i+15:16i].
- in_pc  in  XLEN  PC of lane 0; lane i PC = in_pc+i.
- rf_raddr  out  LANES*2*RAW_W  combinational read addresses; lane i rs1 at index 2i, rs2 at index 2i+1.
- rf_rdata  in  LANES*2*XLEN  combinational read data, same ordering as rf_raddr.
- out_valid  out  LANES  thermometer mask of valid output slots.
- out_ready  in  1  issue accepts the output group (low = stall).
- out_opcode  out  LANES*4  per-slot opcode.
- out_rd  out  LANES*RAW_W  per-slot destination register.
- out_imm  out  LANES*5  per-slot raw immediate.
- out_imm_flag  out  LANES  per-slot immediate select.
- out_op1  out  LANES*XLEN  per-slot rs1 value.
- out_op2  out  LANES*XLEN  per-slot rs2 value or sign-extended immediate.
- out_branch_target  out  LANES*XLEN  per-slot PC + sext(imm), branch lanes only.

Behaviour:
- Instruction format: opcode[15:12], rd[11:9], rs1[8:6], imm_flag[5]. imm_flag=1: imm[4:0]. imm_flag=0: rs2[4:2].
- writes_rd = opcode not in {0, OPC_BRANCH, OPC_STORE}.
- RAW hazard: lane k reads rs1 (or rs2 when imm_flag=0) equal to rd of an earlier writing lane j, where start<=j<k.
- op2 = imm_flag ? sext(imm) : rf rs2 data.
- branch_target = lane PC + sext(imm), modulo 2^XLEN. Target is 0 for non-branch lanes. out_imm is 0 when imm_flag=0.
- Reset (async, active-low): out_valid=0 and all out_* cleared to 0; FSM=IDLE; held bundle and start index cleared.
- FSM IDLE:
  - in_ready = !(|out_valid) || out_ready, and !flush.
  - On accept, issue lanes 0..k-1, where k is the first hazard lane; k=LANES if there is no hazard.
  - If k<LANES, latch bundle and PC, set start=k, go to SPLIT.
- FSM SPLIT:
  - in_ready=0.
  - On each advance (out_ready or output empty), issue lanes start..k'-1 from the held bundle, compacted to slot 0.
  - Return to IDLE when k'=LANES.
- Latency: one cycle from accept to out_valid. A hazard-free bundle sustains one bundle per cycle.
- Output registers hold while out_valid!=0 and out_ready=0. rf_raddr is driven from the current decode source (input bundle in IDLE, held bundle in SPLIT).
- flush has priority over everything:
  - next cycle out_valid=0, FSM=IDLE, held residual dropped.
  - A bundle presented in the flush cycle is not accepted.
- Reset asserted mid-SPLIT aborts immediately; no partial group is emitted.

Optional Feature:
- Macro DEC_R0_ZERO_EN.
- When defined: reads of r0 return 0 regardless of rf_rdata, and rd=r0 never creates a RAW hazard.
- When undefined: r0 is an ordinary register.

Test Plan:
1. Reset: hold reset=0 with in_valid=1 for 2 cycles -> out_valid=0, in_ready=0, all outputs 0. Release -> in_ready=1.
2. No hazard, rf r1=0x0005, r2=0x0007, bundle {0x1648, 0x1A62}, pc=0x0010 -> next cycle out_valid=2'b11. Slot0 op1=0x0005, op2=0x0007, rd=3. Slot1 op2=0x0002, imm_flag=1.
3. RAW split, bundle {0x1648, 0x18E1} -> cycle1 out_valid=2'b01, in_ready=0. Cycle2 out_valid=2'b01 with slot0 opcode=1, rd=4, op2=0x0001. Then in_ready=1.
4. Branch: lane0=0xD07E, pc=0x0040 -> out_branch_target slot0=0x003E, out_imm=5'h1E, op2=0xFFFE.
5. Stall: out_ready=0 for 3 cycles after a valid group -> outputs stable, in_ready=0. new in_instr=0x3A51 not accepted until out_ready=1.
6. Flush during SPLIT (scenario 3, flush in cycle1) -> cycle2 out_valid=0, FSM IDLE, residual lane never emitted.
